ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: address of the first instruction fetched after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low; one clock, no other clock domains.
REQ-004 NPCop  input  3  next-PC select from ctrl: 000 PC+4, 001 beq, 010 jal, 011 jr, others treated as 000.
REQ-005 Zero  input  1  ALU equality flag; used only when NPCop=001.
REQ-006 RA  input  32  GPR[rs] read data, the jr target.
REQ-007 stall  input  1  holds the current instruction in EXEC while high.
REQ-008 imem_req  output  1  instruction-memory read request.
REQ-009 imem_addr  output  32  word address of the fetch, {PC[31:2],2'b00}.
REQ-010 imem_ready  input  1  memory accepts and returns data this cycle when high with imem_req.
REQ-011 imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-012 instr  output  32  registered current instruction.
REQ-013 opcode  output  6  instr[31:26]; Func  output  6  instr[5:0].
REQ-014 instr_valid  output  1  high only in EXEC; downstream gates RegWrite/MemWrite with it.
REQ-015 PC  output  32  address of the current instruction; PC4  output  32  PC+4 (jal link value).

Function
REQ-016 FSM has two states: FETCH and EXEC.
REQ-017 FETCH: imem_req=1, instr_valid=0, imem_addr=PC; advances to EXEC on the edge where imem_ready=1, capturing imem_rdata into instr; otherwise remains in FETCH.
REQ-018 imem_addr and imem_req stay stable in FETCH until imem_ready=1.
REQ-019 Minimum fetch latency is one cycle (imem_ready high in the first FETCH cycle); each instruction therefore occupies at least 2 cycles.
REQ-020 EXEC: imem_req=0, instr_valid=1, instr held constant.
REQ-021 EXEC with stall=1: remain in EXEC; PC and instr unchanged; instr_valid stays 1.
REQ-022 EXEC with stall=0: on the edge, PC <= NPC and the FSM returns to FETCH.
REQ-023 NPC for 000/100-111: PC+4, 32-bit modulo; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-024 NPC for 001: Zero=1 gives PC+4+(sign_extend(instr[15:0])<<2), mod 2^32; Zero=0 gives PC+4.
REQ-025 NPC for 010: {PC4[31:28], instr[25:0], 2'b00}.
REQ-026 NPC for 011: {RA[31:2], 2'b00}; low bits of an unaligned RA are discarded.
REQ-027 NPCop, Zero and RA are sampled only on the EXEC-exit edge; their values in FETCH are ignored.
REQ-028 PC4 = PC+4 combinationally in all states.
REQ-029 opcode and Func are slices of the instr register, never of imem_rdata.

Reset
REQ-030 reset_n=0 asynchronously forces state=FETCH, PC=RESET_PC, instr=32'h0, instr_valid=0.
REQ-031 While reset_n=0, imem_req=0.
REQ-032 A reset asserted mid-FETCH or mid-EXEC abandons the access; no PC update occurs.
REQ-033 The first rising edge after reset_n rises begins FETCH at RESET_PC with imem_req=1.

Verification
REQ-034 Reset release with imem_ready=1 constantly, all NPCop=000: fetch addresses 0x3000, 0x3004, 0x3008; instr_valid pattern 0,1,0,1.
REQ-035 PC=0x3010, instr=0x1000FFFF (beq, offset -1), NPCop=001: Zero=1 gives next fetch at 0x3010; Zero=0 gives 0x3014.
REQ-036 PC=0x3020, instr=0x0C000C40 (jal), NPCop=010: next PC 0x3100; PC4=0x3024 during EXEC.
REQ-037 NPCop=011, RA=0x0000_3047: next PC 0x3044; NPCop=101 treated as PC+4.
REQ-038 imem_ready low for 3 cycles, then high: imem_addr stable over 4 cycles, EXEC entered once; stall=1 for 2 EXEC cycles keeps instr_valid=1 with PC unchanged.
REQ-039 reset_n pulsed low mid-EXEC of PC=0x3008: outputs reset immediately (no edge needed); restart at 0x3000.

Source files
------------

// File: rtl/ifu.sv
// ---------------------------------------------------------------------------
// ifu -- instruction fetch unit for a multi-cycle MIPS-style core.
//
// A two-state FSM alternates FETCH (request the word at PC from instruction
// memory, wait for imem_ready) and EXEC (hold the fetched instruction for the
// rest of the core, optionally stretched by stall). Leaving EXEC loads the
// next PC chosen by NPCop.
//
// Ports:
//   clk          clock, all state on the rising edge
//   reset_n      asynchronous active-low reset
//   NPCop[2:0]   next-PC select: 000 PC+4, 001 beq, 010 jal, 011 jr, else PC+4
//   Zero         ALU equality flag, only used for beq
//   RA[31:0]     jr target (GPR[rs])
//   stall        holds the current instruction in EXEC
//   imem_req     instruction-memory read request (FETCH only)
//   imem_addr    word-aligned fetch address
//   imem_ready   memory accepts/returns data this cycle
//   imem_rdata   returned instruction word
//   instr        registered current instruction
//   opcode/Func  instr[31:26] / instr[5:0]
//   instr_valid  high only in EXEC
//   PC / PC4     current instruction address / PC+4 (jal link value)
// ---------------------------------------------------------------------------
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  NPCop,
    input  logic        Zero,
    input  logic [31:0] RA,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  Func,
    output logic        instr_valid,
    output logic [31:0] PC,
    output logic [31:0] PC4
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_req;
    logic        r_valid;

    logic [31:0] w_pc4;
    logic [31:0] w_br_off;
    logic [31:0] w_npc;

    assign w_pc4    = r_pc + 32'd4;
    // Branch offset is a signed word count; scale to bytes after sign extension.
    assign w_br_off = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

    always_comb begin
        w_npc = w_pc4;
        case (NPCop)
            3'b001:  w_npc = Zero ? (w_pc4 + w_br_off) : w_pc4;
            3'b010:  w_npc = (w_pc4 & 32'hF000_0000) | {4'b0000, r_instr[25:0], 2'b00};
            3'b011:  w_npc = RA & 32'hFFFF_FFFC;
            default: w_npc = w_pc4;
        endcase
    end

    // r_req is cleared by reset so no request is visible while reset_n is low;
    // the first edge after release raises it, which opens the first FETCH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_instr <= 32'h0;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
        end else if (r_state == S_FETCH) begin
            if (r_req && imem_ready) begin
                r_state <= S_EXEC;
                r_instr <= imem_rdata;
                r_req   <= 1'b0;
                r_valid <= 1'b1;
            end else begin
                r_req   <= 1'b1;
            end
        end else begin
            // NPCop/Zero/RA only matter on this exit edge.
            if (!stall) begin
                r_state <= S_FETCH;
                r_pc    <= w_npc;
                r_req   <= 1'b1;
                r_valid <= 1'b0;
            end
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc & 32'hFFFF_FFFC;
    assign instr       = r_instr;
    assign opcode      = r_instr[31:26];
    assign Func        = r_instr[5:0];
    assign instr_valid = r_valid;
    assign PC          = r_pc;
    assign PC4         = w_pc4;

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk;
    logic        reset_n;
    logic [2:0]  NPCop;
    logic        Zero;
    logic [31:0] RA;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  Func;
    logic        instr_valid;
    logic [31:0] PC;
    logic [31:0] PC4;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what the spec says the unit should be showing.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_exec;
    logic        m_started;

    ifu #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .NPCop      (NPCop),
        .Zero       (Zero),
        .RA         (RA),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .opcode     (opcode),
        .Func       (Func),
        .instr_valid(instr_valid),
        .PC         (PC),
        .PC4        (PC4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Next PC from the architectural rules, using plain integer arithmetic.
    function automatic logic [31:0] npc_ref(input logic [31:0] pc, input logic [31:0] ins,
                                            input logic [2:0] op, input logic z,
                                            input logic [31:0] ra);
        int          off;
        logic [31:0] t;
        off = int'($signed(ins[15:0]));
        case (op)
            3'd1:    t = z ? (pc + 32'd4 + 32'(off * 4)) : (pc + 32'd4);
            3'd2:    t = ((pc + 32'd4) & 32'hF000_0000) + (32'(ins[25:0]) * 32'd4);
            3'd3:    t = ra - (ra % 4);
            default: t = pc + 32'd4;
        endcase
        return t;
    endfunction

    task automatic model_reset();
        m_pc      = RST_PC;
        m_instr   = 32'h0;
        m_exec    = 1'b0;
        m_started = 1'b0;
    endtask

    task automatic check_all();
        chk("instr_valid", 32'(instr_valid), 32'(m_exec));
        chk("imem_req", 32'(imem_req), 32'(m_started && !m_exec));
        chk("PC", PC, m_pc);
        chk("PC4", PC4, m_pc + 32'd4);
        chk("imem_addr", imem_addr, m_pc);
        chk("instr", instr, m_instr);
        chk("opcode", 32'(opcode), 32'(m_instr >> 26));
        chk("Func", 32'(Func), m_instr % 64);
    endtask

    // One clock: predict from the inputs currently driven, then compare.
    task automatic tick();
        logic [31:0] pc_n;
        logic [31:0] instr_n;
        logic        exec_n;
        pc_n    = m_pc;
        instr_n = m_instr;
        exec_n  = m_exec;
        if (m_exec) begin
            if (!stall) begin
                pc_n   = npc_ref(m_pc, m_instr, NPCop, Zero, RA);
                exec_n = 1'b0;
            end
        end else if (m_started && imem_ready) begin
            instr_n = imem_rdata;
            exec_n  = 1'b1;
        end
        @(posedge clk);
        #1;
        m_pc      = pc_n;
        m_instr   = instr_n;
        m_exec    = exec_n;
        m_started = 1'b1;
        check_all();
    endtask

    // One full instruction: fetch after dly not-ready cycles, stall stl cycles,
    // then leave EXEC with the given next-PC controls. Control inputs carry
    // junk whenever they should be ignored.
    task automatic run_instr(input logic [31:0] rd, input logic [2:0] op, input logic z,
                             input logic [31:0] ra, input int dly, input int stl);
        NPCop = 3'($urandom); Zero = 1'($urandom); RA = $urandom; stall = 1'($urandom);
        for (int k = 0; k < 4 && !m_started; k++) begin
            imem_ready = 1'($urandom);
            tick();
        end
        imem_ready = 1'b0;
        for (int k = 0; k < dly; k++) begin
            imem_rdata = $urandom;
            tick();
        end
        imem_ready = 1'b1;
        imem_rdata = rd;
        tick();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        stall = 1'b1;
        for (int k = 0; k < stl; k++) tick();
        stall = 1'b0;
        NPCop = op; Zero = z; RA = ra;
        tick();
    endtask

    initial begin
        logic [31:0] a0;
        reset_n = 1'b0; NPCop = 3'd0; Zero = 1'b0; RA = 32'h0; stall = 1'b0;
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        chk("reset_req", 32'(imem_req), 32'h0);

        // Release away from an edge; sequential fetches with ready always high.
        #2 reset_n = 1'b1;
        run_instr(32'h0000_0020, 3'd0, 1'b0, 32'h0, 0, 0);
        chk("seq_pc1", PC, 32'h0000_3004);
        run_instr(32'h2000_0001, 3'd0, 1'b0, 32'h0, 0, 0);
        chk("seq_pc2", PC, 32'h0000_3008);

        // Fetch 0x3008, stall in EXEC, then reset asynchronously mid-EXEC.
        chk("fetch3_addr", imem_addr, 32'h0000_3008);
        imem_ready = 1'b1; imem_rdata = 32'h1234_5678; tick();
        imem_ready = 1'b0; stall = 1'b1; tick();
        chk("exec3_valid", 32'(instr_valid), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_rst_valid", 32'(instr_valid), 32'h0);
        chk("async_rst_pc", PC, RST_PC);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        stall = 1'b0; imem_ready = 1'b1;
        tick();
        chk("restart_req", 32'(imem_req), 32'h1);
        chk("restart_addr", imem_addr, 32'h0000_3000);

        // jr with unaligned target, then jr to 0x3010 for the branch cases.
        run_instr(32'h03E0_0008, 3'd3, 1'b0, 32'h0000_3047, 0, 0);
        chk("jr_unaligned", PC, 32'h0000_3044);
        run_instr(32'h03E0_0008, 3'd3, 1'b0, 32'h0000_3010, 1, 0);
        run_instr(32'h1000_FFFF, 3'd1, 1'b1, 32'h0, 0, 0);
        chk("beq_taken", PC, 32'h0000_3010);
        run_instr(32'h1000_FFFF, 3'd1, 1'b0, 32'h0, 0, 0);
        chk("beq_not_taken", PC, 32'h0000_3014);

        // jal from 0x3020.
        run_instr(32'h03E0_0008, 3'd3, 1'b0, 32'h0000_3020, 0, 0);
        chk("pre_jal_pc4", PC4, 32'h0000_3024);
        run_instr(32'h0C00_0C40, 3'd2, 1'b0, 32'h0, 0, 1);
        chk("jal_target", PC, 32'h0000_3100);
        run_instr(32'h0000_0000, 3'd5, 1'b1, 32'hFFFF_FFFF, 0, 0);
        chk("npcop5", PC, 32'h0000_3104);

        // Slow memory (3 not-ready cycles) and a 2-cycle stall.
        a0 = imem_addr;
        imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("addr_stable", imem_addr, a0);
        end
        run_instr(32'hAC01_0004, 3'd0, 1'b0, 32'h0, 0, 2);
        chk("slow_next_pc", PC, 32'h0000_3108);

        // Address wrap at the top of memory.
        run_instr(32'h03E0_0008, 3'd3, 1'b0, 32'hFFFF_FFFC, 0, 0);
        run_instr(32'h0000_0000, 3'd0, 1'b0, 32'h0, 0, 0);
        chk("pc_wrap", PC, 32'h0000_0000);

        // Randomised instructions against the reference model.
        for (int n = 0; n < 80; n++) begin
            run_instr($urandom, 3'($urandom_range(0, 7)), 1'($urandom), $urandom,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
